// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Iterative RV32M multiply/divide (radix-2 shift-add, restoring div)
// Revision : 1.0  initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] c_min     = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] c_last    = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [2:0]           r_op;
    logic                 r_neg;
    logic [WIDTH-1:0]     r_y;
    logic [2*WIDTH-1:0]   r_acc;

    // Operand preparation on the request side
    logic             w_sgn_a, w_sgn_b, w_neg_a, w_neg_b;
    logic             w_div_zero, w_ovf, w_fast;
    logic [WIDTH-1:0] w_mag_a, w_mag_b;

    assign w_sgn_a    = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
    assign w_sgn_b    = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01);
    assign w_neg_a    = w_sgn_a & a[WIDTH-1];
    assign w_neg_b    = w_sgn_b & b[WIDTH-1];
    assign w_mag_a    = w_neg_a ? -a : a;
    assign w_mag_b    = w_neg_b ? -b : b;
    assign w_div_zero = funct3[2] && (b == {WIDTH{1'b0}});
    assign w_ovf      = funct3[2] && !funct3[0] && (a == c_min) && (b == {WIDTH{1'b1}});
    assign w_fast     = w_div_zero | w_ovf;

    // Multiply step: multiplier sits in the low half and shifts out as the product shifts in
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;

    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_y : {WIDTH{1'b0}})};
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide step: remainder in the high half, dividend/quotient in the low half
    logic [WIDTH:0]     w_div_shift, w_div_trial;
    logic               w_div_ok;
    logic [2*WIDTH-1:0] w_div_next;

    assign w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_trial = w_div_shift - {1'b0, r_y};
    assign w_div_ok    = ~w_div_trial[WIDTH];
    assign w_div_next  = {(w_div_ok ? w_div_trial[WIDTH-1:0] : w_div_shift[WIDTH-1:0]),
                          r_acc[WIDTH-2:0], w_div_ok};

    // Sign fix-up and word selection
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_dsel, w_dval, w_fix;

    assign w_prod = r_neg ? -r_acc : r_acc;
    assign w_dsel = r_op[1] ? r_acc[2*WIDTH-1:WIDTH] : r_acc[WIDTH-1:0];
    assign w_dval = r_neg ? -w_dsel : w_dsel;
    assign w_fix  = r_op[2] ? w_dval :
                    (r_op[1:0] == 2'b00) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_neg   <= 1'b0;
            r_y     <= '0;
            r_acc   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !flush) begin
                        r_op  <= funct3;
                        r_y   <= w_mag_b;
                        r_cnt <= '0;
                        busy  <= 1'b1;
                        if (w_fast) begin
                            // Special results are preloaded so FIX passes them straight through
                            r_neg   <= 1'b0;
                            r_acc   <= w_div_zero ? {a, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, c_min};
                            r_state <= S_FIX;
                        end else begin
                            r_neg   <= (funct3[2] && funct3[1]) ? w_neg_a : (w_neg_a ^ w_neg_b);
                            r_acc   <= {{WIDTH{1'b0}}, w_mag_a};
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= r_op[2] ? w_div_next : w_mul_next;
                        if (r_cnt == c_last) begin
                            r_state <= S_FIX;
                        end else begin
                            r_cnt <= r_cnt + c_cnt_one;
                        end
                    end
                end
                S_FIX: begin
                    if (flush) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        result  <= w_fix;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Brief    : Scoreboard bench for muldiv_unit against an arithmetic reference
// Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  funct3;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] result;

    muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush), .funct3(funct3),
        .a(a), .b(b), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          acc;
        int          edges;
        logic [2:0]  f;
    } exp_t;

    exp_t        q[$];
    exp_t        m_e;
    int          cyc = 0;
    int          bcnt = 0;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] last_exp = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, ux, uy, p;
        int     ix, iy;
        sx = $signed(x);
        sy = $signed(y);
        ux = longint'({32'h0, x});
        uy = longint'({32'h0, y});
        ix = x;
        iy = y;
        p  = 0;
        case (f)
            3'd0: begin p = sx * sy; return p[31:0];  end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
                return ix / iy;
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
                return ix % iy;
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int edges_for(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        if (f[2] && (y == 0 || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))) return 2;
        return 34;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT signals done
    always @(negedge clk) begin
        if (done) begin
            check("busy_low_at_done", {31'h0, busy}, 32'h0);
            if (q.size() == 0) begin
                check("unexpected_done", 32'h1, 32'h0);
            end else begin
                m_e = q.pop_front();
                check($sformatf("result_f%0d", m_e.f), result, m_e.res);
                check($sformatf("latency_f%0d", m_e.f), cyc - m_e.acc + 1, m_e.edges);
                check($sformatf("busy_cycles_f%0d", m_e.f), bcnt, m_e.edges - 1);
            end
            bcnt = 0;
        end else if (busy) begin
            bcnt = bcnt + 1;
        end else begin
            bcnt = 0;
        end
    end

    task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y, input bit expect_it);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while ((busy || done) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy || done) check("idle_wait_timeout", 32'h1, 32'h0);
        start  = 1'b1;
        funct3 = f;
        a      = x;
        b      = y;
        @(posedge clk);
        #1;
        start  = 1'b0;
        funct3 = 3'($urandom_range(0, 7));
        a      = $urandom;
        b      = $urandom;
        check("busy_after_accept", {31'h0, busy}, 32'h1);
        if (expect_it) begin
            e.res    = ref_model(f, x, y);
            e.acc    = cyc;
            e.edges  = edges_for(f, x, y);
            e.f      = f;
            last_exp = e.res;
            q.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", q.size(), 0);
        q.delete();
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            4:       return 32'h0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic [2:0]  f;
        logic [31:0] x, y, r;
    } dir_t;

    dir_t dir_tab[12] = '{
        '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB},
        '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
        '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
        '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF},
        '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD},
        '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF},
        '{3'd5, 32'd100,       32'd7,         32'd14},
        '{3'd7, 32'd100,       32'd7,         32'd2},
        '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF},
        '{3'd7, 32'd5,         32'd0,         32'd5},
        '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
        '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000}
    };

    initial begin
        #500000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b1; flush = 1'b0;
        funct3 = 3'd5; a = 32'd5; b = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(posedge clk);
        #1;
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_done", {31'h0, done}, 32'h0);
        check("reset_result", result, 32'h0);

        // Directed table: constants are the architecturally expected results
        foreach (dir_tab[i]) begin
            check($sformatf("model_dir%0d", i), ref_model(dir_tab[i].f, dir_tab[i].x, dir_tab[i].y), dir_tab[i].r);
            issue(dir_tab[i].f, dir_tab[i].x, dir_tab[i].y, 1'b1);
        end
        drain();

        // Flush in the middle of a multiply
        issue(3'd0, 32'd3, 32'd5, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", {31'h0, busy}, 32'h0);
        check("flush_result_held", result, last_exp);
        repeat (40) @(negedge clk);
        check("flush_result_later", result, last_exp);
        issue(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 1'b1);
        drain();

        // Start pulses while busy must not queue a second operation
        issue(3'd5, 32'd1000, 32'd3, 1'b1);
        repeat (5) @(negedge clk);
        start = 1'b1; funct3 = 3'd0; a = 32'd1; b = 32'd1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (40) @(negedge clk);

        // Reset in the middle of an operation
        issue(3'd3, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midop_reset_result", result, 32'h0);
        check("midop_reset_busy", {31'h0, busy}, 32'h0);
        check("midop_reset_done", {31'h0, done}, 32'h0);
        last_exp = 32'h0;
        repeat (40) @(negedge clk);
        issue(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
        drain();

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            issue(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 1'b1);
        end
        drain();

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
